// File: rtl/unloader_mem_arbiter.sv
// rtl/unloader_mem_arbiter.sv - single-port memory arbiter merging the unloader read strobe with a core valid/ready port
//
// Purpose:
//   Drives one synchronous-read memory from two sources. The unloader
//   always wins and gets its data at a fixed cycle. Core accesses use the
//   remaining cycles, and core reads come back as a one-cycle valid pulse.
//
// Ports:
//   clk_memory        sole clock
//   reset_n           asynchronous active-low reset
//   unload_read_en    unloader strobe; only its rising edge is a request
//   unload_read_addr  unloader address, sampled on the rising-edge cycle
//   unload_read_data  registered unloader data, held until the next capture
//   core_valid        core request present
//   core_ready        combinational; transfer on core_valid && core_ready
//   core_we           1 = write, 0 = read
//   core_addr         core address
//   core_wdata        core write data
//   core_rd_valid     one-cycle pulse marking core_rd_data valid
//   core_rd_data      core read data
//   mem_rd / mem_wr   memory strobes, one cycle per access
//   mem_addr          memory address (held while idle)
//   mem_wr_data       memory write data (held while idle)
//   mem_rd_data       memory read data, valid MEM_LATENCY cycles after mem_rd

module unloader_mem_arbiter #(
   parameter int ADDRESS_SIZE = 28,
   parameter int DATA_WIDTH   = 8,
   parameter int MEM_LATENCY  = 1
) (
   input  logic                    clk_memory,
   input  logic                    reset_n,

   input  logic                    unload_read_en,
   input  logic [ADDRESS_SIZE-1:0] unload_read_addr,
   output logic [DATA_WIDTH-1:0]   unload_read_data,

   input  logic                    core_valid,
   output logic                    core_ready,
   input  logic                    core_we,
   input  logic [ADDRESS_SIZE-1:0] core_addr,
   input  logic [DATA_WIDTH-1:0]   core_wdata,
   output logic                    core_rd_valid,
   output logic [DATA_WIDTH-1:0]   core_rd_data,

   output logic                    mem_rd,
   output logic                    mem_wr,
   output logic [ADDRESS_SIZE-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wr_data,
   input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

   logic                   prev_en;
   logic                   unload_rise;
   logic                   core_xfer;
   logic                   issue_unload;
   logic [MEM_LATENCY-1:0] tag_valid;
   logic [MEM_LATENCY-1:0] tag_unload;

   // A strobe held high across reset release counts as a fresh edge,
   // because prev_en comes out of reset at 0.
   assign unload_rise = unload_read_en & ~prev_en;
   assign core_ready  = reset_n & ~unload_rise;
   assign core_xfer   = core_valid & core_ready;

   always_ff @(posedge clk_memory or negedge reset_n) begin
      if (!reset_n) begin
         prev_en <= 1'b0;
      end else begin
         prev_en <= unload_read_en;
      end
   end

   // Issue stage: one access per cycle, unloader first.
   always_ff @(posedge clk_memory or negedge reset_n) begin
      if (!reset_n) begin
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_wr_data  <= '0;
         issue_unload <= 1'b0;
      end else begin
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         issue_unload <= 1'b0;
         if (unload_rise) begin
            mem_rd       <= 1'b1;
            mem_addr     <= unload_read_addr;
            issue_unload <= 1'b1;
         end else if (core_xfer) begin
            mem_addr <= core_addr;
            if (core_we) begin
               mem_wr      <= 1'b1;
               mem_wr_data <= core_wdata;
            end else begin
               mem_rd <= 1'b1;
            end
         end
      end
   end

   // Return tags travel beside the memory read. Stage 0 is loaded from the
   // issue registers, so the last stage lines up with the cycle in which
   // mem_rd_data is valid. Writes and idle cycles shift in invalid tags.
   always_ff @(posedge clk_memory or negedge reset_n) begin
      if (!reset_n) begin
         tag_valid  <= '0;
         tag_unload <= '0;
      end else begin
         tag_valid[0]  <= mem_rd;
         tag_unload[0] <= issue_unload;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_valid[i]  <= tag_valid[i-1];
            tag_unload[i] <= tag_unload[i-1];
         end
      end
   end

   // Return routing: each returning word goes to exactly one destination.
   always_ff @(posedge clk_memory or negedge reset_n) begin
      if (!reset_n) begin
         unload_read_data <= '0;
         core_rd_data     <= '0;
         core_rd_valid    <= 1'b0;
      end else begin
         core_rd_valid <= 1'b0;
         if (tag_valid[MEM_LATENCY-1]) begin
            if (tag_unload[MEM_LATENCY-1]) begin
               unload_read_data <= mem_rd_data;
            end else begin
               core_rd_data  <= mem_rd_data;
               core_rd_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_unloader_mem_arbiter.sv
// tb/tb_unloader_mem_arbiter.sv - randomized bench for unloader_mem_arbiter with a cycle-scheduled reference model

module tb_unloader_mem_arbiter;

   localparam int AW = 28;
   localparam int DW = 8;

   logic          clk_memory;
   logic          reset_n;
   logic          unload_read_en;
   logic [AW-1:0] unload_read_addr;
   logic [DW-1:0] unload_read_data;
   logic          core_valid;
   logic          core_ready;
   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic          core_rd_valid;
   logic [DW-1:0] core_rd_data;
   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_data;
   logic [DW-1:0] mem_rd_data;

   int checks = 0;
   int errors = 0;

   unloader_mem_arbiter #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut (
      .clk_memory       (clk_memory),
      .reset_n          (reset_n),
      .unload_read_en   (unload_read_en),
      .unload_read_addr (unload_read_addr),
      .unload_read_data (unload_read_data),
      .core_valid       (core_valid),
      .core_ready       (core_ready),
      .core_we          (core_we),
      .core_addr        (core_addr),
      .core_wdata       (core_wdata),
      .core_rd_valid    (core_rd_valid),
      .core_rd_data     (core_rd_data),
      .mem_rd           (mem_rd),
      .mem_wr           (mem_wr),
      .mem_addr         (mem_addr),
      .mem_wr_data      (mem_wr_data),
      .mem_rd_data      (mem_rd_data)
   );

   initial begin
      clk_memory = 1'b0;
      forever #5 clk_memory = ~clk_memory;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Memory device: 256 words keyed by addr[7:0], each word initialised to
   // its own index; one cycle read latency.
   logic [DW-1:0] phys_mem [256];
   initial begin
      logic          rd;
      logic [AW-1:0] a;
      for (int i = 0; i < 256; i++) phys_mem[i] = 8'(i);
      mem_rd_data = '0;
      forever begin
         @(negedge clk_memory);
         rd = mem_rd;
         a  = mem_addr;
         if (mem_wr) phys_mem[mem_addr[7:0]] = mem_wr_data;
         @(posedge clk_memory);
         #1;
         if (rd) mem_rd_data = phys_mem[a[7:0]];
      end
   end

   // Reference model: expectations scheduled by absolute cycle number.
   logic [DW-1:0] ref_mem [256];
   logic          exp_mrd   [8];
   logic          exp_mwr   [8];
   logic [AW-1:0] exp_addr  [8];
   logic [DW-1:0] exp_wdata [8];
   logic          exp_cv    [8];
   logic [DW-1:0] exp_cdata [8];
   logic          exp_uset  [8];
   logic [DW-1:0] exp_uval  [8];
   logic [DW-1:0] model_unload;
   logic          model_prev;
   logic          hold;

   task automatic clear_slots();
      for (int i = 0; i < 8; i++) begin
         exp_mrd[i] = 1'b0; exp_mwr[i] = 1'b0; exp_addr[i] = '0; exp_wdata[i] = '0;
         exp_cv[i] = 1'b0; exp_cdata[i] = '0; exp_uset[i] = 1'b0; exp_uval[i] = '0;
      end
   endtask

   initial begin
      int cyc;
      int s, n1, n3;
      logic rise;
      cyc = 0;
      hold = 1'b0;
      model_prev = 1'b0;
      model_unload = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
      clear_slots();
      forever begin
         @(negedge clk_memory);
         if (!reset_n) begin
            chk("rst_core_ready", 32'(core_ready), 32'd0);
            chk("rst_mem_rd", 32'(mem_rd), 32'd0);
            chk("rst_mem_wr", 32'(mem_wr), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
            chk("rst_unload_data", 32'(unload_read_data), 32'd0);
            chk("rst_core_rd_valid", 32'(core_rd_valid), 32'd0);
            chk("rst_core_rd_data", 32'(core_rd_data), 32'd0);
            clear_slots();
            model_prev = 1'b0;
            model_unload = '0;
            hold = 1'b0;
         end else begin
            s = cyc % 8;
            chk("mem_rd", 32'(mem_rd), 32'(exp_mrd[s]));
            chk("mem_wr", 32'(mem_wr), 32'(exp_mwr[s]));
            if (exp_mrd[s] || exp_mwr[s]) chk("mem_addr", 32'(mem_addr), 32'(exp_addr[s]));
            if (exp_mwr[s]) chk("mem_wr_data", 32'(mem_wr_data), 32'(exp_wdata[s]));
            chk("core_rd_valid", 32'(core_rd_valid), 32'(exp_cv[s]));
            if (exp_cv[s]) chk("core_rd_data", 32'(core_rd_data), 32'(exp_cdata[s]));
            if (exp_uset[s]) model_unload = exp_uval[s];
            chk("unload_read_data", 32'(unload_read_data), 32'(model_unload));
            exp_mrd[s] = 1'b0; exp_mwr[s] = 1'b0; exp_cv[s] = 1'b0; exp_uset[s] = 1'b0;

            rise = unload_read_en && !model_prev;
            chk("core_ready", 32'(core_ready), 32'(!rise));
            n1 = (cyc + 1) % 8;
            n3 = (cyc + 3) % 8;
            if (rise) begin
               exp_mrd[n1]  = 1'b1;
               exp_addr[n1] = unload_read_addr;
               exp_uset[n3] = 1'b1;
               exp_uval[n3] = ref_mem[unload_read_addr[7:0]];
            end else if (core_valid) begin
               exp_addr[n1] = core_addr;
               if (core_we) begin
                  exp_mwr[n1]   = 1'b1;
                  exp_wdata[n1] = core_wdata;
                  ref_mem[core_addr[7:0]] = core_wdata;
               end else begin
                  exp_mrd[n1]   = 1'b1;
                  exp_cv[n3]    = 1'b1;
                  exp_cdata[n3] = ref_mem[core_addr[7:0]];
               end
            end
            hold = core_valid && rise;
            model_prev = unload_read_en;
         end
         cyc++;
      end
   end

   task automatic drive(input logic rn, input logic en, input logic [AW-1:0] ua,
                        input logic cv, input logic we, input logic [AW-1:0] ca,
                        input logic [DW-1:0] wd);
      @(posedge clk_memory);
      #1;
      reset_n = rn; unload_read_en = en; unload_read_addr = ua;
      core_valid = cv; core_we = we; core_addr = ca; core_wdata = wd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [31:0] r;
      logic          en;
      logic [AW-1:0] ua;
      logic          cv;
      logic          we;
      logic [AW-1:0] ca;
      logic [DW-1:0] wd;
      reset_n = 1'b0; unload_read_en = 1'b0; unload_read_addr = '0;
      core_valid = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      repeat (3) @(posedge clk_memory);
      idle(2);

      // Unloader read, then a long idle hold
      drive(1'b1, 1'b1, 28'h0000123, 1'b0, 1'b0, '0, '0);
      idle(10);
      // Held strobe gives one request
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 28'h0000055, 1'b0, 1'b0, '0, '0);
      idle(4);
      // Pipelined core reads
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 28'h10, '0);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 28'h11, '0);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 28'h12, '0);
      idle(4);
      // Collision: unloader wins, core retries next cycle
      drive(1'b1, 1'b1, 28'h40, 1'b1, 1'b0, 28'h50, '0);
      drive(1'b1, 1'b1, 28'h40, 1'b1, 1'b0, 28'h50, '0);
      idle(5);
      // Write then read back
      drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 28'h7, 8'hA5);
      idle(1);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 28'h7, '0);
      idle(4);
      // Reset while a core read is in flight
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 28'h33, '0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 28'h34, '0);
      idle(5);
      // Strobe already high when reset releases
      drive(1'b0, 1'b1, 28'hABCDE12, 1'b0, 1'b0, '0, '0);
      drive(1'b0, 1'b1, 28'hABCDE12, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b1, 28'hABCDE12, 1'b1, 1'b0, 28'h21, '0);
      drive(1'b1, 1'b1, 28'hABCDE12, 1'b1, 1'b0, 28'h21, '0);
      idle(5);

      // Randomized traffic; a stalled core request is held unchanged
      en = 1'b0; ua = '0; cv = 1'b0; we = 1'b0; ca = '0; wd = '0;
      for (int k = 0; k < 600; k++) begin
         r  = $urandom;
         en = (r[1:0] == 2'b00) ? ~en : en;
         r  = $urandom;
         ua = (r[31:30] == 2'b00) ? r[27:0] : {20'h0, r[7:0]};
         if (!hold) begin
            r  = $urandom;
            cv = r[0] | r[1];
            we = r[2] & r[3];
            ca = r[31] ? {r[27:8], 3'b000, r[4:0]} : {23'h0, r[8:4]};
            wd = r[20:13];
         end
         drive(1'b1, en, ua, cv, we, ca, wd);
      end
      idle(6);
      @(negedge clk_memory);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/unloader_mem_arbiter.md
# unloader_mem_arbiter

Single-port memory arbiter in the memory clock domain, directly downstream of the APF data unloader's memory side. It merges the unloader's fixed-latency read strobe (`read_en`/`read_addr`/`read_data`) with a core read/write port on a valid/ready handshake, and drives one synchronous-read memory. The unloader always has priority, and its data arrives at a guaranteed cycle. Core accesses fill the remaining cycles and return read data through a valid pulse.

## Interface
- `ADDRESS_SIZE`, 28, memory address width.
- `DATA_WIDTH`, 8, memory/unloader word width; legal values 8 or 16.
- `MEM_LATENCY`, 1, cycles from `mem_rd` high to valid `mem_rd_data`; legal range 1–4.
- `clk_memory`  in  1  sole clock; all logic rises on it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `unload_read_en`  in  1  unloader read strobe; only its rising edge is a request.
- `unload_read_addr`  in  ADDRESS_SIZE  unloader address; sampled on the rising-edge cycle.
- `unload_read_data`  out  DATA_WIDTH  registered unloader read data; held until the next unloader read completes.
- `core_valid`  in  1  core request present.
- `core_ready`  out  1  combinational; transfer when `core_valid && core_ready`.
- `core_we`  in  1  1 = write, 0 = read.
- `core_addr`  in  ADDRESS_SIZE  core address.
- `core_wdata`  in  DATA_WIDTH  core write data.
- `core_rd_valid`  out  1  one-cycle pulse marking `core_rd_data` valid.
- `core_rd_data`  out  DATA_WIDTH  core read data.
- `mem_rd`  out  1  memory read strobe, one cycle per access.
- `mem_wr`  out  1  memory write strobe, one cycle per access.
- `mem_addr`  out  ADDRESS_SIZE  memory address.
- `mem_wr_data`  out  DATA_WIDTH  memory write data.
- `mem_rd_data`  in  DATA_WIDTH  memory read data; valid `MEM_LATENCY` cycles after `mem_rd`.

## Operation
- Edge detect:
  - `prev_en` is registered each cycle.
  - `unload_rise = unload_read_en & ~prev_en`.
  - A held-high `unload_read_en` produces exactly one request.
- `core_ready = ~unload_rise` while `reset_n` is high; otherwise 0.
- Issue stage (registered, next edge):
  - If `unload_rise`: `mem_rd=1`, `mem_wr=0`, `mem_addr=unload_read_addr`, tag = UNLOAD.
  - Else if a core transfer occurs:
    - Write: `mem_wr=1`, `mem_addr=core_addr`, `mem_wr_data=core_wdata`.
    - Read: `mem_rd=1`, `mem_addr=core_addr`, tag = CORE.
  - Else: `mem_rd=0`, `mem_wr=0`. `mem_addr` and `mem_wr_data` hold their last values.
- Return pipeline:
  - A tag shift register, `MEM_LATENCY` deep, carries {valid, UNLOAD/CORE} alongside each `mem_rd`. Writes push an invalid tag.
  - When a valid tag exits: UNLOAD captures `mem_rd_data` into `unload_read_data`; CORE captures it into `core_rd_data` and pulses `core_rd_valid` for 1 cycle.
- Throughput:
  - One access per cycle.
  - Back-to-back core reads are fully pipelined.
  - No stall is needed on the return path; every issued read returns exactly once.
- Collision: an unloader edge and `core_valid` in the same cycle → the unloader issues; `core_ready=0`; the core holds its request and transfers on the next free cycle.
- Widths:
  - Addresses pass through unmodified; no increment or truncation.
  - `core_rd_data` and `unload_read_data` are exactly `DATA_WIDTH`.

## Timing
- Unloader edge in cycle T:
  - `mem_rd` high in T+1.
  - `mem_rd_data` valid in T+1+MEM_LATENCY.
  - `unload_read_data` valid from T+2+MEM_LATENCY until the next unloader capture.
- The unloader's read-delay parameter must be ≥ MEM_LATENCY+2 (3 at default).
- Core read transferred in cycle T:
  - `core_rd_valid` high in exactly T+2+MEM_LATENCY.
  - Responses return in issue order.
- Core write transferred in cycle T: `mem_wr` high in T+1; no response.
- Reset (asynchronous assert, synchronous-safe release). All of the following are 0:
  - `mem_rd`, `mem_wr`, `mem_addr`, `mem_wr_data`
  - `unload_read_data`, `core_rd_data`, `core_rd_valid`
  - `prev_en`, all tags
- Reset mid-operation discards in-flight reads: no `core_rd_valid` pulse for pre-reset requests, and `unload_read_data` stays 0.
- `unload_read_en` already high when reset releases: `prev_en=0`, so it counts as a rising edge on the first cycle out of reset.

## Test plan
- Unloader read: `mem` model returns addr[7:0]; pulse `unload_read_en` with addr 0x0000123 at T → `mem_rd` at T+1, `unload_read_data`=0x23 at T+3; value holds for 10 idle cycles.
- Held strobe: `unload_read_en` high for 5 cycles → exactly one `mem_rd`.
- Pipelined core reads: core reads 0x10,0x11,0x12 on consecutive cycles → `core_rd_valid` 3 consecutive cycles with data 0x10,0x11,0x12, first at T+3.
- Collision: unloader edge (addr 0x40) and core read 0x50 in the same cycle → `core_ready`=0; `mem_addr` 0x40 then 0x50; each result routed only to its own port.
- Core write: write 0xA5 to 0x7 → `mem_wr`=1 one cycle, `mem_addr`=0x7, `mem_wr_data`=0xA5; no `core_rd_valid`.
- Reset mid-flight: core read issued, `reset_n` low the next cycle for 2 cycles → all outputs 0, no `core_rd_valid` ever produced; a fresh read after release returns correct data at T+3.
